program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised program counter with a hardware call/return stack, the next-generation address source for the CPU control path. Produces the instruction fetch address and supports sequential increment, absolute jump, subroutine call (push return address, load target) and return (pop). Stack overflow and underflow are trapped as sticky error flags instead of corrupting the address. It replaces the fixed 4-bit counter wherever wider memories or subroutines are required.

## Interface
Parameters:
- ADDR_W, default 4: address width in bits, 2..16.
- DEPTH, default 4: return-stack entries, 1..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- count_en  in  1  advance addr by one.
- jump  in  1  load addr from jump_addr.
- call  in  1  push return address, load addr from jump_addr.
- ret  in  1  pop stack into addr.
- jump_addr  in  ADDR_W  target for jump/call.
- addr  out  ADDR_W  current fetch address, registered.
- sp  out  $clog2(DEPTH+1)  number of valid stack entries, registered.
- overflow  out  1  sticky: call attempted with stack full.
- underflow  out  1  sticky: ret attempted with stack empty.

## Operation
- Exactly one operation per cycle, selected by fixed priority: rst > call > ret > jump > count_en > hold.
- Lower-priority requests asserted in the same cycle are dropped, not queued.
- count_en: addr <= addr + 1, modulo 2^ADDR_W; all-ones wraps to 0.
- jump: addr <= jump_addr; stack untouched.
- call with sp < DEPTH:
  - stack[sp] <= addr + 1 (wrapped);
  - sp <= sp + 1;
  - addr <= jump_addr.
- call with sp == DEPTH: no push, addr holds, overflow <= 1.
- ret with sp > 0:
  - addr <= stack[sp-1];
  - sp <= sp - 1.
- ret with sp == 0: addr holds, underflow <= 1.
- overflow and underflow clear only on rst.
- Errors do not block further operations; a later legal call or ret proceeds normally.
- Stack entry contents are don't-care when unused; only sp defines validity.

## Timing
- Reset values: addr = 0, sp = 0, overflow = 0, underflow = 0. Stack storage is not reset.
- rst asserted mid-sequence overrides every request in that cycle. The next cycle starts empty at address 0.
- Latency: every operation takes effect on the rising edge where it is sampled; the result appears on the outputs in the following cycle.
- No combinational path from any input to any output.
- Back-to-back call/ret is legal every cycle. A ret immediately after a call returns to the call's addr + 1.
- All outputs change only on clk rising edge.

## Structure
- Package program_sequencer_pkg:
  - op enum: OP_NONE, OP_COUNT, OP_JUMP, OP_CALL, OP_RET;
  - function computing SP_W = $clog2(DEPTH+1).
- Priority decode is a small combinational block producing the op enum.
- The address register and error flags live in program_sequencer.
- Sub-module pc_return_stack, a LIFO of DEPTH x ADDR_W:
  - push/pop/data-in/top/full/empty/count;
  - push on full and pop on empty are ignored internally;
  - same synchronous active-high reset on count.

## Test plan
Parameters ADDR_W=4, DEPTH=2 unless stated.
- Reset and wrap: rst, then count_en for 16 cycles -> addr steps 0..15, then 0. sp stays 0, flags 0.
- Jump vs count: addr=3, jump=1, count_en=1, jump_addr=9 -> next addr=9, not 4.
- Nested call/return:
  - at addr=2, call to 8 -> addr=8, sp=1;
  - at addr=8, call to 12 -> addr=12, sp=2;
  - ret -> addr=9, sp=1;
  - ret -> addr=3, sp=0.
- Overflow:
  - sp=2, addr=5, call to 1 -> addr stays 5, sp=2, overflow=1;
  - a following ret -> pops the correct top entry; overflow stays 1.
- Underflow and priority:
  - sp=0, ret=1 with count_en=1 -> addr unchanged, underflow=1, no increment;
  - call and ret together at sp=0 -> call wins, sp=1.
- Reset mid-stack, ADDR_W=8, DEPTH=4:
  - three calls, then rst with call asserted -> addr=0, sp=0, both flags 0;
  - a following ret -> underflow=1.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and helpers for the program sequencer and its return stack.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_COUNT,
    OP_JUMP,
    OP_CALL,
    OP_RET
  } op_e;

  // Width of a counter that must hold every value from 0 up to depth.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; push on full and pop on empty are silently ignored.
module pc_return_stack
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  localparam int SP_W  = sp_width(DEPTH),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic [SP_W-1:0]   count
);

  localparam logic [SP_W-1:0] FULL_COUNT = SP_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[IDX_W'(count - SP_W'(1))];

  // NOTE: storage has no reset; the count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[IDX_W'(count)] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (push && !full) count <= count + SP_W'(1);
    else if (pop && !empty) count <= count - SP_W'(1);
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address generator: increment, jump, call/return through a hardware
// stack, with sticky overflow/underflow traps.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  localparam int SP_W  = sp_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [SP_W-1:0]   sp,
  output logic              overflow,
  output logic              underflow
);

  op_e               op;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full;
  logic              stack_empty;

  // NOTE: op gets a default before the priority chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op = OP_NONE;
    if (call)          op = OP_CALL;
    else if (ret)      op = OP_RET;
    else if (jump)     op = OP_JUMP;
    else if (count_en) op = OP_COUNT;
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (op == OP_CALL),
    .pop   (op == OP_RET),
    .din   (addr + ADDR_W'(1)),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty),
    .count (sp)
  );

  // A trapped call/ret leaves addr where it was; only the flag records it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (op)
        OP_COUNT: addr <= addr + ADDR_W'(1);
        OP_JUMP:  addr <= jump_addr;
        OP_CALL: begin
          if (stack_full) overflow <= 1'b1;
          else            addr     <= jump_addr;
        end
        OP_RET: begin
          if (stack_empty) underflow <= 1'b1;
          else             addr      <= stack_top;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: instance A (ADDR_W=4, DEPTH=2) and instance B (ADDR_W=8, DEPTH=4).
module tb_program_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, count_en_a, jump_a, call_a, ret_a;
  logic [3:0] jump_addr_a, addr_a;
  logic [1:0] sp_a;
  logic       overflow_a, underflow_a;

  logic       rst_b, count_en_b, jump_b, call_b, ret_b;
  logic [7:0] jump_addr_b, addr_b;
  logic [2:0] sp_b;
  logic       overflow_b, underflow_b;

  program_sequencer #(.ADDR_W(4), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .count_en(count_en_a), .jump(jump_a), .call(call_a),
    .ret(ret_a), .jump_addr(jump_addr_a), .addr(addr_a), .sp(sp_a),
    .overflow(overflow_a), .underflow(underflow_a)
  );

  program_sequencer #(.ADDR_W(8), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .count_en(count_en_b), .jump(jump_b), .call(call_b),
    .ret(ret_b), .jump_addr(jump_addr_b), .addr(addr_b), .sp(sp_b),
    .overflow(overflow_b), .underflow(underflow_b)
  );

  typedef struct {
    logic       r, ce, j, c, rt;
    logic [7:0] ja;
    logic [7:0] ea;
    logic [2:0] esp;
    logic       eo, eu;
    string      nm;
  } row_t;

  typedef struct {
    logic [12:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic row_t mk(input logic r, ce, j, c, rt, input logic [7:0] ja,
                              input logic [7:0] ea, input logic [2:0] esp,
                              input logic eo, eu, input string nm);
    row_t x;
    x.r = r; x.ce = ce; x.j = j; x.c = c; x.rt = rt; x.ja = ja;
    x.ea = ea; x.esp = esp; x.eo = eo; x.eu = eu; x.nm = nm;
    return x;
  endfunction

  function automatic logic [12:0] obs_a();
    return {4'b0, addr_a, 1'b0, sp_a, overflow_a, underflow_a};
  endfunction

  function automatic logic [12:0] obs_b();
    return {addr_b, sp_b, overflow_b, underflow_b};
  endfunction

  task automatic push_exp(input row_t rw);
    exp_t e;
    e.v  = {rw.ea, rw.esp, rw.eo, rw.eu};
    e.nm = rw.nm;
    sb.push_back(e);
  endtask

  task automatic apply_a(input row_t rw);
    rst_a = rw.r; count_en_a = rw.ce; jump_a = rw.j; call_a = rw.c; ret_a = rw.rt;
    jump_addr_a = rw.ja[3:0];
    push_exp(rw);
  endtask

  task automatic apply_b(input row_t rw);
    rst_b = rw.r; count_en_b = rw.ce; jump_b = rw.j; call_b = rw.c; ret_b = rw.rt;
    jump_addr_b = rw.ja;
    push_exp(rw);
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(1,1,1,1,1, 8'h7, 8'h0, 3'd0, 0, 0, "reset_all_req"),
             mk(0,0,0,0,0, 8'h0, 8'h0, 3'd0, 0, 0, "reset_hold")};
    foreach (rows[i]) begin
      apply_a(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got addr/sp/ov/un=%h required %h", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [12:0] o;
    for (int i = 0; i < 16; i++) begin
      apply_a(mk(0,1,0,0,0, 8'h0, 8'((i + 1) % 16), 3'd0, 0, 0, "count_wrap"));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s step %0d: got %h required %h", e.nm, i, o, e.v);
      end
    end
  endtask

  task automatic test_jump_priority();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(0,0,1,0,0, 8'h3, 8'h3, 3'd0, 0, 0, "jump_to_3"),
             mk(0,1,1,0,0, 8'h9, 8'h9, 3'd0, 0, 0, "jump_beats_count")};
    foreach (rows[i]) begin
      apply_a(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_nested();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(0,0,1,0,0, 8'h2, 8'h2, 3'd0, 0, 0, "nest_jump_2"),
             mk(0,0,0,1,0, 8'h8, 8'h8, 3'd1, 0, 0, "nest_call_8"),
             mk(0,0,0,1,0, 8'hc, 8'hc, 3'd2, 0, 0, "nest_call_12"),
             mk(0,0,0,0,1, 8'h0, 8'h9, 3'd1, 0, 0, "nest_ret_9"),
             mk(0,0,0,0,1, 8'h0, 8'h3, 3'd0, 0, 0, "nest_ret_3")};
    foreach (rows[i]) begin
      apply_a(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_overflow();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(0,0,1,0,0, 8'h6, 8'h6, 3'd0, 0, 0, "ovf_jump_6"),
             mk(0,0,0,1,0, 8'ha, 8'ha, 3'd1, 0, 0, "ovf_call_10"),
             mk(0,0,0,1,0, 8'h4, 8'h4, 3'd2, 0, 0, "ovf_call_4"),
             mk(0,1,0,0,0, 8'h0, 8'h5, 3'd2, 0, 0, "ovf_count_5"),
             mk(0,0,0,1,0, 8'h1, 8'h5, 3'd2, 1, 0, "ovf_call_full"),
             mk(0,0,0,0,1, 8'h0, 8'hb, 3'd1, 1, 0, "ovf_ret_top"),
             mk(0,0,0,0,1, 8'h0, 8'h7, 3'd0, 1, 0, "ovf_ret_bottom")};
    foreach (rows[i]) begin
      apply_a(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_underflow_priority();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(0,1,0,0,1, 8'h0, 8'h7, 3'd0, 1, 1, "unf_ret_beats_count"),
             mk(0,0,0,1,1, 8'h3, 8'h3, 3'd1, 1, 1, "call_beats_ret"),
             mk(0,0,0,1,0, 8'hc, 8'hc, 3'd2, 1, 1, "b2b_call"),
             mk(0,0,0,0,1, 8'h0, 8'h4, 3'd1, 1, 1, "b2b_ret"),
             mk(0,0,0,0,1, 8'h0, 8'h8, 3'd0, 1, 1, "ret_after_err"),
             mk(1,1,1,1,1, 8'h5, 8'h0, 3'd0, 0, 0, "rst_clears_flags")};
    foreach (rows[i]) begin
      apply_a(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_a();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_stack();
    row_t rows[$];
    exp_t e;
    logic [12:0] o;
    rows = '{mk(1,0,0,0,0, 8'h00, 8'h00, 3'd0, 0, 0, "b_reset"),
             mk(0,0,0,1,0, 8'h10, 8'h10, 3'd1, 0, 0, "b_call_1"),
             mk(0,0,0,1,0, 8'h20, 8'h20, 3'd2, 0, 0, "b_call_2"),
             mk(0,0,0,1,0, 8'h30, 8'h30, 3'd3, 0, 0, "b_call_3"),
             mk(1,0,0,1,0, 8'h40, 8'h00, 3'd0, 0, 0, "b_rst_over_call"),
             mk(0,0,0,0,1, 8'h00, 8'h00, 3'd0, 0, 1, "b_ret_underflow")};
    foreach (rows[i]) begin
      apply_b(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = obs_b();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, o, e.v);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; count_en_a = 1'b0; jump_a = 1'b0; call_a = 1'b0; ret_a = 1'b0;
    jump_addr_a = '0;
    rst_b = 1'b1; count_en_b = 1'b0; jump_b = 1'b0; call_b = 1'b0; ret_b = 1'b0;
    jump_addr_b = '0;
    @(posedge clk); #1;
    test_reset();
    test_wrap();
    test_jump_priority();
    test_nested();
    test_overflow();
    test_underflow_priority();
    test_reset_mid_stack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
